// File: rtl/mole_game_sequencer_pkg.sv
// Shared types and constants for the Whac-A-Mole game controller: state encoding,
// LFSR seed/taps and score width.
package whac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int SCORE_W = 16;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mole_game_sequencer_if.sv
// Game-controller bus: player/timer inputs toward the sequencer and the
// timer-control, display and score outputs back out.
interface mole_game_sequencer_if #(
    parameter int NUM_MOLES           = 18,
    parameter int GAME_LENGTH_SECONDS = 20
);
    import whac_pkg::*;

    localparam int IDX_W = $clog2(NUM_MOLES);
    localparam int MS_W  = $clog2(1000 * GAME_LENGTH_SECONDS);

    logic                 start;
    logic                 pause;
    logic                 hit_valid;
    logic [IDX_W-1:0]     hit_idx;
    logic [MS_W-1:0]      timer_ms_left;
    logic                 timer_rst;
    logic                 timer_enable;
    logic [2:0]           state;
    logic [NUM_MOLES-1:0] mole_mask;
    logic [SCORE_W-1:0]   score;
    logic                 hit_accept;
    logic                 game_over;

    modport master (
        output start, pause, hit_valid, hit_idx, timer_ms_left,
        input  timer_rst, timer_enable, state, mole_mask, score, hit_accept, game_over
    );

    modport slave (
        input  start, pause, hit_valid, hit_idx, timer_ms_left,
        output timer_rst, timer_enable, state, mole_mask, score, hit_accept, game_over
    );

endinterface

// File: rtl/mole_game_sequencer_lfsr.sv
// 16-bit Galois LFSR used to pick mole positions; free-running whenever adv is high.
module mole_lfsr
    import whac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (adv) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/mole_game_sequencer.sv
// Whac-A-Mole round sequencer: idle/ready/play/over phases, mole scheduling and scoring.
// Define MOLE_GAME_PAUSE_EN to build in the PAUSE state.
module mole_game_sequencer
    import whac_pkg::*;
#(
    parameter int GAME_LENGTH_SECONDS = 20,
    parameter int CLKS_PER_MS         = 50000,
    parameter int NUM_MOLES           = 18,
    parameter int READY_MS            = 3000,
    parameter int GAP_MS              = 200,
    parameter int MOLE_UP_MS_START    = 1000,
    parameter int MOLE_UP_MS_MIN      = 400,
    parameter int MOLE_UP_STEP_MS     = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    mole_game_sequencer_if.slave bus
);

    localparam int IDX_W   = $clog2(NUM_MOLES);
    localparam int MS_W    = $clog2(1000 * GAME_LENGTH_SECONDS);
    localparam int PRE_W   = $clog2(CLKS_PER_MS + 1);
    localparam int CNT_MAX = (READY_MS > GAP_MS)
                           ? ((READY_MS > MOLE_UP_MS_START) ? READY_MS : MOLE_UP_MS_START)
                           : ((GAP_MS > MOLE_UP_MS_START) ? GAP_MS : MOLE_UP_MS_START);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LOAD   = PRE_W'(CLKS_PER_MS - 1);
    localparam logic [CNT_W-1:0] READY_LOAD = CNT_W'(READY_MS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_MS - 1);
    localparam logic [CNT_W-1:0] UP_START   = CNT_W'(MOLE_UP_MS_START);
    localparam logic [CNT_W-1:0] UP_MIN     = CNT_W'(MOLE_UP_MS_MIN);
    localparam logic [CNT_W-1:0] UP_STEP    = CNT_W'(MOLE_UP_STEP_MS);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_MOLES - 1);

    game_state_t          st;
    logic                 timer_rst_q, timer_en_q, hit_acc_q, game_over_q;
    logic [NUM_MOLES-1:0] mask_q, next_mask;
    logic [SCORE_W-1:0]   score_q;
    logic [PRE_W-1:0]     presc;
    logic [CNT_W-1:0]     ms_cnt, up_ms, up_next;
    logic                 up_phase, prev_valid;
    logic [IDX_W-1:0]     cur_idx, raw_idx, next_idx;
    logic [15:0]          lfsr_q, prod;
    logic                 tick, hit_ok, game_end;
    logic                 unused_lfsr_hi;

    mole_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (1'b1),
        .q   (lfsr_q)
    );

    assign unused_lfsr_hi = ^lfsr_q[15:8];

    assign prod     = 16'(lfsr_q[7:0]) * 16'(NUM_MOLES);
    assign raw_idx  = IDX_W'(prod >> 8);
    assign tick     = (presc == '0);
    assign hit_ok   = up_phase && bus.hit_valid && (bus.hit_idx == cur_idx);
    assign game_end = (bus.timer_ms_left == MS_W'(0));

    always_comb begin
        next_idx = raw_idx;
        if (prev_valid && (raw_idx == cur_idx)) begin
            next_idx = (raw_idx == IDX_LAST) ? '0 : raw_idx + IDX_W'(1);
        end
        next_mask = {{(NUM_MOLES-1){1'b0}}, 1'b1} << next_idx;
        up_next   = (int'(up_ms) >= MOLE_UP_MS_MIN + MOLE_UP_STEP_MS) ? up_ms - UP_STEP : UP_MIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= ST_IDLE;
            timer_rst_q <= 1'b1;
            timer_en_q  <= 1'b0;
            mask_q      <= '0;
            score_q     <= '0;
            hit_acc_q   <= 1'b0;
            game_over_q <= 1'b0;
            presc       <= PRE_LOAD;
            ms_cnt      <= '0;
            up_ms       <= UP_START;
            up_phase    <= 1'b0;
            cur_idx     <= '0;
            prev_valid  <= 1'b0;
        end else begin
            hit_acc_q <= 1'b0;
            case (st)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        st          <= ST_READY;
                        score_q     <= '0;
                        timer_rst_q <= 1'b1;
                        timer_en_q  <= 1'b0;
                        game_over_q <= 1'b0;
                        presc       <= PRE_LOAD;
                        ms_cnt      <= READY_LOAD;
                    end
                end
                ST_READY: begin
                    presc <= tick ? PRE_LOAD : presc - PRE_W'(1);
                    if (tick) begin
                        if (ms_cnt == '0) begin
                            st          <= ST_PLAY;
                            timer_rst_q <= 1'b0;
                            timer_en_q  <= 1'b1;
                            presc       <= PRE_LOAD;
                            ms_cnt      <= GAP_LOAD;
                            up_phase    <= 1'b0;
                            up_ms       <= UP_START;
                            prev_valid  <= 1'b0;
                        end else begin
                            ms_cnt <= ms_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    presc <= tick ? PRE_LOAD : presc - PRE_W'(1);
                    if (hit_ok) begin
                        // Realign the prescaler so the post-hit gap is a full GAP_MS.
                        score_q   <= (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                        hit_acc_q <= 1'b1;
                        mask_q    <= '0;
                        up_phase  <= 1'b0;
                        ms_cnt    <= GAP_LOAD;
                        presc     <= PRE_LOAD;
                        up_ms     <= up_next;
                    end else if (tick) begin
                        if (ms_cnt != '0) begin
                            ms_cnt <= ms_cnt - CNT_W'(1);
                        end else if (up_phase) begin
                            mask_q   <= '0;
                            up_phase <= 1'b0;
                            ms_cnt   <= GAP_LOAD;
                            up_ms    <= up_next;
                        end else begin
                            mask_q     <= next_mask;
                            cur_idx    <= next_idx;
                            prev_valid <= 1'b1;
                            up_phase   <= 1'b1;
                            ms_cnt     <= up_ms - CNT_W'(1);
                        end
                    end
                    if (game_end) begin
                        st          <= ST_OVER;
                        timer_en_q  <= 1'b0;
                        timer_rst_q <= 1'b0;
                        mask_q      <= '0;
                        game_over_q <= 1'b1;
                    end
`ifdef MOLE_GAME_PAUSE_EN
                    else if (bus.pause) begin
                        st         <= ST_PAUSE;
                        timer_en_q <= 1'b0;
                    end
`endif
                end
`ifdef MOLE_GAME_PAUSE_EN
                ST_PAUSE: begin
                    if (bus.pause) begin
                        st         <= ST_PLAY;
                        timer_en_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef MOLE_GAME_PAUSE_EN
    logic unused_pause;
    assign unused_pause = bus.pause;
`endif

    assign bus.state        = st;
    assign bus.timer_rst    = timer_rst_q;
    assign bus.timer_enable = timer_en_q;
    assign bus.mole_mask    = mask_q;
    assign bus.score        = score_q;
    assign bus.hit_accept   = hit_acc_q;
    assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_mole_game_sequencer.sv
// Self-checking bench for mole_game_sequencer with short timing parameters;
// hit results go through a scoreboard queue, mole indices through an LFSR model.
module tb_mole_game_sequencer;
    import whac_pkg::*;

    localparam int NUM_MOLES = 18;
    localparam int IDX_W     = $clog2(NUM_MOLES);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mole_game_sequencer_if #(.NUM_MOLES(NUM_MOLES), .GAME_LENGTH_SECONDS(20)) bus ();

    mole_game_sequencer #(
        .GAME_LENGTH_SECONDS (20),
        .CLKS_PER_MS         (4),
        .NUM_MOLES           (NUM_MOLES),
        .READY_MS            (3),
        .GAP_MS              (2),
        .MOLE_UP_MS_START    (10),
        .MOLE_UP_MS_MIN      (4),
        .MOLE_UP_STEP_MS     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference LFSR; m_prev is the value the DUT sampled at the most recent edge.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    typedef struct packed {
        logic                 acc;
        logic [15:0]          score;
        logic [NUM_MOLES-1:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   model_score = 0;
    bit   have_prev   = 0;
    int   last_idx    = 0;

    task automatic do_hit(input int idx, input bit good);
        exp_t e;
        if (good) model_score++;
        e.acc   = good;
        e.score = 16'(model_score);
        e.mask  = good ? '0 : bus.mole_mask;
        sb_q.push_back(e);
        bus.hit_valid = 1'b1;
        bus.hit_idx   = IDX_W'(idx);
        @(negedge clk);
        bus.hit_valid = 1'b0;
        e = sb_q.pop_front();
        check_val("hit_accept", bus.hit_accept, e.acc);
        check_val("hit_score", bus.score, e.score);
        check_val("hit_mask", bus.mole_mask, e.mask);
    endtask

    task automatic wait_mask_zero(output int n);
        n = 0;
        while (bus.mole_mask == '0 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_mask_up(output int n);
        n = 0;
        while (bus.mole_mask != '0 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_rise(output int k);
        int raw;
        check_val("mole_onehot", 32'($onehot(bus.mole_mask)), 1);
        k = 0;
        for (int i = 0; i < NUM_MOLES; i++) if (bus.mole_mask[i]) k = i;
        raw = (int'(m_prev[7:0]) * NUM_MOLES) >> 8;
        if (have_prev && raw == last_idx) raw = (raw + 1) % NUM_MOLES;
        check_val("mole_idx", k, raw);
        have_prev = 1;
        last_idx  = k;
    endtask

    initial begin
        int n, k, k_prev;
        bit flag_ok;
        logic [NUM_MOLES-1:0] held;
        int up_exp[5] = '{40, 32, 24, 16, 16};

        bus.start         = 1'b0;
        bus.pause         = 1'b0;
        bus.hit_valid     = 1'b0;
        bus.hit_idx       = '0;
        bus.timer_ms_left = 15'd20000;
        rst               = 1'b1;
        repeat (3) @(negedge clk);

        check_val("rst_state", bus.state, 0);
        check_val("rst_timer_rst", bus.timer_rst, 1);
        check_val("rst_timer_en", bus.timer_enable, 0);
        check_val("rst_mask", bus.mole_mask, 0);
        check_val("rst_score", bus.score, 0);
        check_val("rst_hit_accept", bus.hit_accept, 0);
        check_val("rst_game_over", bus.game_over, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_hold", bus.state, 0);

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("start_ready", bus.state, 1);
        check_val("ready_score", bus.score, 0);
        n = 0;
        flag_ok = 1;
        while (bus.state == 3'd1 && n < 100) begin
            if (bus.timer_rst !== 1'b1 || bus.mole_mask != '0) flag_ok = 0;
            n++;
            @(negedge clk);
        end
        check_val("ready_cycles", n, 12);
        check_val("ready_outputs", flag_ok, 1);
        check_val("play_state", bus.state, 2);
        check_val("play_timer_en", bus.timer_enable, 1);
        check_val("play_timer_rst", bus.timer_rst, 0);
        have_prev = 0;

        wait_mask_zero(n);
        check_val("first_gap", n, 8);
        check_rise(k);

        // Five consecutive misses walk the up-time down to its floor.
        for (int i = 0; i < 5; i++) begin
            wait_mask_up(n);
            check_val("up_time", n, up_exp[i]);
            if (i == 0) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                check_val("start_in_play", bus.state, 2);
            end else if (i == 4) begin
                do_hit(k, 1'b0);
            end else begin
                @(negedge clk);
            end
            wait_mask_zero(n);
            check_val("gap_len", n + 1, 8);
            check_rise(k);
        end

        do_hit((k + 1) % NUM_MOLES, 1'b0);
        do_hit(k, 1'b1);
        k_prev = k;
        @(negedge clk);
        check_val("accept_one_cycle", bus.hit_accept, 0);
        wait_mask_zero(n);
        check_val("post_hit_gap", n + 1, 8);
        check_rise(k);
        check_val("new_idx_differs", 32'(k != k_prev), 1);

        held      = bus.mole_mask;
        bus.pause = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.pause = 1'b0;
        bus.start = 1'b0;
`ifdef MOLE_GAME_PAUSE_EN
        check_val("pause_state", bus.state, 3);
        check_val("pause_timer_en", bus.timer_enable, 0);
        check_val("pause_mask", bus.mole_mask, held);
        do_hit(k, 1'b0);
        flag_ok = 1;
        repeat (98) begin
            @(negedge clk);
            if (bus.state != 3'd3 || bus.mole_mask != held || bus.timer_enable !== 1'b0) flag_ok = 0;
        end
        check_val("pause_frozen", flag_ok, 1);
        bus.pause = 1'b1;
        @(negedge clk);
        bus.pause = 1'b0;
`endif
        check_val("resume_state", bus.state, 2);
        check_val("resume_timer_en", bus.timer_enable, 1);
        wait_mask_up(n);
        check_val("remaining_up", n, 15);

        wait_mask_zero(n);
        check_val("gap_after_pause", n, 8);
        check_rise(k);

        // Scoring hit lands in the same cycle the timer reads zero.
        bus.timer_ms_left = '0;
        do_hit(k, 1'b1);
        check_val("over_state", bus.state, 4);
        check_val("over_flag", bus.game_over, 1);
        check_val("over_timer_en", bus.timer_enable, 0);
        check_val("over_timer_rst", bus.timer_rst, 0);
        flag_ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (bus.state != 3'd4 || bus.score != 16'd2 || bus.mole_mask != '0 || bus.hit_accept) flag_ok = 0;
        end
        check_val("over_hold", flag_ok, 1);

        bus.timer_ms_left = 15'd20000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("restart_state", bus.state, 1);
        check_val("restart_score", bus.score, 0);
        check_val("restart_game_over", bus.game_over, 0);
        check_val("restart_timer_rst", bus.timer_rst, 1);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midgame_rst_state", bus.state, 0);
        check_val("midgame_rst_timer_rst", bus.timer_rst, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
